// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and helpers for the 1-to-5 stream demux.
//   NUM_DEST / DEST_W : destination count and destination index width
//   DEST_*            : destination indices, in decode order
//   dest_t, state_t   : destination index type and routing FSM states
//   dest_decode()     : maps (sel, if_sel) onto a destination index
package stream_demux_pkg;

  localparam int NUM_DEST = 5;
  localparam int DEST_W   = 3;

  typedef logic [DEST_W-1:0] dest_t;

  localparam dest_t DEST_IF0 = 3'd0;
  localparam dest_t DEST_IF1 = 3'd1;
  localparam dest_t DEST_IN1 = 3'd2;
  localparam dest_t DEST_IN2 = 3'd3;
  localparam dest_t DEST_IN3 = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,  // no packet open; next accepted beat decodes sel/if_sel
    LOCK = 1'b1   // packet open; destination held until the last beat
  } state_t;

  // sel==00 splits on if_sel (if_sel=1 is destination 0); other sel codes
  // map directly onto destinations 2..4.
  function automatic dest_t dest_decode(input logic [1:0] sel, input logic if_sel);
    dest_t d;
    case (sel)
      2'b00:   d = if_sel ? DEST_IF0 : DEST_IF1;
      2'b01:   d = DEST_IN1;
      2'b10:   d = DEST_IN2;
      default: d = DEST_IN3;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/stream_demux_reg.sv
// stream_demux_reg: one-entry valid/ready pipeline register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o/in_payload_i    : upstream side
//   out_valid_o/out_ready_i/out_payload_o : downstream side
// Handshake: a beat moves on an edge where valid & ready are both high;
// valid never depends on ready, and the payload holds while valid is low.
// in_ready_o is combinational in out_ready_i so a drain and a reload can
// happen on the same edge (full throughput, no bubble).
module stream_demux_reg #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [PW-1:0] in_payload_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [PW-1:0] out_payload_o
);

  logic          full_q, full_d;
  logic [PW-1:0] payload_q, payload_d;

  always_comb begin
    in_ready_o = !full_q || out_ready_i;
    full_d     = full_q;
    payload_d  = payload_q;
    if (in_valid_i && in_ready_o) begin
      full_d    = 1'b1;
      payload_d = in_payload_i;
    end else if (out_ready_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= 1'b0;
      payload_q <= '0;
    end else begin
      full_q    <= full_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid_o   = full_q;
  assign out_payload_o = payload_q;

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-5 stream demultiplexer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   sel_i, if_sel_i     : destination select, sampled on the first beat only
//   in_valid_i/in_ready_o/in_data_i/in_last_i : input stream
//   out_valid_o[4:0]    : one-hot per-destination valid
//   out_ready_i[4:0]    : per-destination ready
//   out_data_o, out_last_o : payload and last flag shared by all destinations
//   stat_cnt_o          : per-destination saturating beat counters, dest d at
//                         [d*CNT_W +: CNT_W]; only with STREAM_DEMUX_STAT_EN
//   dbg_state_o         : routing FSM state
// Handshake: a beat transfers on an edge where valid & ready are both high.
// The beat in the output register keeps its own destination, so a stalled
// consumer blocks the whole stream (head-of-line blocking is intended).
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          sel_i,
  input  logic                if_sel_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DW-1:0]       in_data_i,
  input  logic                in_last_i,
  output logic [NUM_DEST-1:0] out_valid_o,
  input  logic [NUM_DEST-1:0] out_ready_i,
  output logic [DW-1:0]       out_data_o,
  output logic                out_last_o,
`ifdef STREAM_DEMUX_STAT_EN
  output logic [NUM_DEST*CNT_W-1:0] stat_cnt_o,
`endif
  output state_t              dbg_state_o
);

  localparam int PW = DW + 1 + DEST_W;

  state_t state_q, state_d;
  dest_t  dest_q, dest_d;
  dest_t  in_dest;
  dest_t  beat_dest;
  logic   accept;
  logic   full;
  logic   sel_ready;
  logic [PW-1:0] reg_payload;

  assign accept = in_valid_i && in_ready_o;

  // The first beat of a packet routes on the live select; later beats reuse
  // the locked destination.
  assign in_dest = (state_q == IDLE) ? dest_decode(sel_i, if_sel_i) : dest_q;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    if (accept) begin
      if (state_q == IDLE) begin
        dest_d  = in_dest;
        state_d = in_last_i ? IDLE : LOCK;
      end else if (in_last_i) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dest_q  <= DEST_IF0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  assign dbg_state_o = state_q;

  // Only the ready of the held beat's destination can drain the register.
  always_comb begin
    sel_ready = 1'b0;
    for (int d = 0; d < NUM_DEST; d++) begin
      if (beat_dest == dest_t'(d)) sel_ready = out_ready_i[d];
    end
  end

  stream_demux_reg #(.PW(PW)) u_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_payload_i ({in_dest, in_last_i, in_data_i}),
    .out_valid_o  (full),
    .out_ready_i  (sel_ready),
    .out_payload_o(reg_payload)
  );

  assign {beat_dest, out_last_o, out_data_o} = reg_payload;

  always_comb begin
    out_valid_o = '0;
    for (int d = 0; d < NUM_DEST; d++) begin
      out_valid_o[d] = full && (beat_dest == dest_t'(d));
    end
  end

`ifdef STREAM_DEMUX_STAT_EN
  logic [CNT_W-1:0] cnt_q [NUM_DEST];

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[g] <= '0;
      end else if (out_valid_o[g] && out_ready_i[g] && (cnt_q[g] != '1)) begin
        cnt_q[g] <= cnt_q[g] + 1'b1;
      end
    end
    assign stat_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed self-checking bench for stream_demux.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge (or just after it), well away from the rising edge.
module tb_stream_demux;
  import stream_demux_pkg::*;

  localparam int DW = 8;
`ifdef STREAM_DEMUX_STAT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic          if_sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic [4:0]    out_valid;
  logic [4:0]    out_ready = '0;
  logic [DW-1:0] out_data;
  logic          out_last;
  state_t        dbg_state;
`ifdef STREAM_DEMUX_STAT_EN
  logic [5*CNT_W-1:0] stat_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Destination table: index d gives the select that routes to dest d.
  logic [1:0] sel_tab [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
  logic       ifs_tab [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  stream_demux #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_i      (sel),
    .if_sel_i   (if_sel),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
`ifdef STREAM_DEMUX_STAT_EN
    .stat_cnt_o (stat_cnt),
`endif
    .dbg_state_o(dbg_state)
  );

  task automatic drive_beat(input logic [1:0] s, input logic ifs,
                            input logic [DW-1:0] d, input logic l);
    in_valid = 1'b1;
    sel      = s;
    if_sel   = ifs;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    out_ready = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 5'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=%b", out_valid, 5'b0);
    end
    checks++;
    if (out_data !== 8'h00 || out_last !== 1'b0) begin
      failures++; $display("FAIL reset_data got=%h/%b exp=00/0", out_data, out_last);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 5'b0) begin
        failures++; $display("FAIL post_reset_valid got=%b exp=%b", out_valid, 5'b0);
      end
    end
  endtask

  task automatic test_single_beats();
    out_ready = 5'b11111;
    for (int d = 0; d < 5; d++) begin
      @(negedge clk);
      drive_beat(sel_tab[d], ifs_tab[d], 8'(8'hA5 + d), 1'b1);
      @(negedge clk);
      drive_idle();
      checks++;
      if (out_valid !== 5'(1 << d) || out_data !== 8'(8'hA5 + d) || out_last !== 1'b1) begin
        failures++;
        $display("FAIL single_beat d=%0d got=%b/%h/%b exp=%b/%h/1",
                 d, out_valid, out_data, out_last, 5'(1 << d), 8'(8'hA5 + d));
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 5'b0 || out_data !== 8'(8'hA5 + d)) begin
        failures++;
        $display("FAIL single_drain d=%0d got=%b/%h exp=00000/%h",
                 d, out_valid, out_data, 8'(8'hA5 + d));
      end
    end
  endtask

  task automatic test_packet_lock();
    out_ready = 5'b11111;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out_valid !== 5'b01000 || out_data !== 8'(8'h10 + i - 1) ||
            out_last !== (i == 4)) begin
          failures++;
          $display("FAIL lock_beat i=%0d got=%b/%h/%b exp=01000/%h/%b",
                   i - 1, out_valid, out_data, out_last, 8'(8'h10 + i - 1), (i == 4));
        end
        checks++;
        if (dbg_state !== ((i == 4) ? IDLE : LOCK)) begin
          failures++; $display("FAIL lock_state i=%0d got=%0d", i, dbg_state);
        end
      end
      if (i == 0)      drive_beat(2'b10, 1'b0, 8'h10, 1'b0);
      else if (i < 4)  drive_beat((i % 2 == 1) ? 2'b00 : 2'b11, 1'b1, 8'(8'h10 + i), i == 3);
      else             drive_idle();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;
    int  idx = 0;
    int  got = 0;
    bit  in_fire = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_fire) idx++;
      if (idx < 3) drive_beat((idx == 0) ? 2'b01 : 2'b10, 1'b1, 8'(8'h20 + idx), idx == 2);
      else         drive_idle();
      out_ready = (c < 6) ? 5'b00001 : 5'b00101;
      #1;
      if (c >= 1 && c <= 5) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 5'b00100 || out_data !== 8'h20) begin
          failures++;
          $display("FAIL bp_hold c=%0d got=%b/%b/%h exp=0/00100/20",
                   c, in_ready, out_valid, out_data);
        end
      end
      in_fire = in_valid && in_ready;
      if (in_fire) exp_q.push_back(in_data);
      if (out_valid[2] && out_ready[2]) begin
        checks++;
        got++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL bp_extra got=%h exp=none", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_data !== exp_v) begin
            failures++; $display("FAIL bp_order got=%h exp=%h", out_data, exp_v);
          end
        end
      end
    end
    checks++;
    if (got != 3 || exp_q.size() != 0) begin
      failures++; $display("FAIL bp_count got=%0d exp=3 left=%0d", got, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int d;
    out_ready = 5'b11111;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        d = (i - 1) % 5;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 5'(1 << d) ||
            out_data !== 8'(8'h40 + i - 1) || out_last !== 1'b1) begin
          failures++;
          $display("FAIL b2b i=%0d got=%b/%b/%h exp=1/%b/%h",
                   i - 1, in_ready, out_valid, out_data, 5'(1 << d), 8'(8'h40 + i - 1));
        end
      end
      if (i < 16) drive_beat(sel_tab[i % 5], ifs_tab[i % 5], 8'(8'h40 + i), 1'b1);
      else        drive_idle();
    end
  endtask

  task automatic test_reset_mid_packet();
    out_ready = 5'b11111;
    @(negedge clk);
    drive_beat(2'b01, 1'b0, 8'h50, 1'b0);
    @(negedge clk);
    drive_beat(2'b01, 1'b0, 8'h51, 1'b0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 5'b0 || out_data !== 8'h00 || out_last !== 1'b0 ||
        in_ready !== 1'b1 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL mid_reset got=%b/%h/%b/%b/%0d exp=00000/00/0/1/%0d",
               out_valid, out_data, out_last, in_ready, dbg_state, IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_beat(2'b11, 1'b0, 8'h66, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 5'b10000 || out_data !== 8'h66) begin
      failures++; $display("FAIL after_reset_route got=%b/%h exp=10000/66", out_valid, out_data);
    end
    drive_beat(2'b00, 1'b1, 8'h67, 1'b1);
    @(negedge clk);
    drive_idle();
    checks++;
    if (out_valid !== 5'b10000 || out_data !== 8'h67 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL after_reset_lock got=%b/%h/%b exp=10000/67/1", out_valid, out_data, out_last);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 5'b0) begin
      failures++; $display("FAIL after_reset_idle got=%b exp=00000", out_valid);
    end
  endtask

`ifdef STREAM_DEMUX_STAT_EN
  task automatic test_stat_saturate();
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      drive_beat(2'b00, 1'b1, 8'(8'h80 + i), 1'b1);
      @(negedge clk);
    end
    drive_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (stat_cnt[1:0] !== 2'd3) begin
      failures++; $display("FAIL stat_sat got=%0d exp=3", stat_cnt[1:0]);
    end
    checks++;
    if (stat_cnt[9:2] !== 8'd0) begin
      failures++; $display("FAIL stat_others got=%h exp=00", stat_cnt[9:2]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_beats();
    test_packet_lock();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
`ifdef STREAM_DEMUX_STAT_EN
    test_stat_saturate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
